// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/almost_full flags and a selectable
// standard or first-word-fall-through read port. Define SYNC_FIFO_DATA_COUNT_EN to add data_count.
module sync_fifo #(
  parameter int    WIDTH     = 8,
  parameter int    DEPTH     = 8,
  parameter string FIFO_TYPE = "std"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full
`ifdef SYNC_FIFO_DATA_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0] data_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_P  = (AW+1)'(DEPTH);
  localparam logic [AW:0] DEPTH_M1 = (AW+1)'(DEPTH - 1);
  localparam bit IS_FWFT = (FIFO_TYPE == "fwft");

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      wr_ptr_nxt, rd_ptr_nxt, occ_nxt;
  logic             wr_eff, rd_eff;
  logic [AW-1:0]    rd_addr;

  assign wr_eff     = wr_en & ~full;
  assign rd_eff     = rd_en & ~empty;
  assign wr_ptr_nxt = wr_ptr + (AW+1)'(wr_eff);
  assign rd_ptr_nxt = rd_ptr + (AW+1)'(rd_eff);
  // Pointer MSB is a wrap flag, so the modular difference is the occupancy.
  assign occ_nxt    = wr_ptr_nxt - rd_ptr_nxt;
  assign rd_addr    = rd_ptr[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      full        <= (occ_nxt == DEPTH_P);
      empty       <= (occ_nxt == '0);
      almost_full <= (occ_nxt >= DEPTH_M1);
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_eff) mem[wr_ptr[AW-1:0]] <= data;
  end

  generate
    if (IS_FWFT) begin : g_fwft
      // Forced to zero while empty so the output is defined out of reset.
      assign dout = empty ? '0 : mem[rd_addr];
    end else begin : g_std
      logic [WIDTH-1:0] dout_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         dout_q <= '0;
        else if (rd_eff) dout_q <= mem[rd_addr];
      end
      assign dout = dout_q;
    end
  endgenerate

`ifdef SYNC_FIFO_DATA_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_count <= '0;
    else     data_count <= occ_nxt;
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo: one standard-mode and one FWFT instance,
// WIDTH=8, DEPTH=8.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en;
  logic [7:0] data, dout;
  logic       full, empty, almost_full;
  logic       f_rst, f_wr_en, f_rd_en;
  logic [7:0] f_data, f_dout;
  logic       f_full, f_empty, f_almost_full;
`ifdef SYNC_FIFO_DATA_COUNT_EN
  logic [3:0] data_count, f_data_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_fifo #(.WIDTH(8), .DEPTH(8), .FIFO_TYPE("std")) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data(data),
    .dout(dout), .full(full), .empty(empty), .almost_full(almost_full)
`ifdef SYNC_FIFO_DATA_COUNT_EN
    , .data_count(data_count)
`endif
  );

  sync_fifo #(.WIDTH(8), .DEPTH(8), .FIFO_TYPE("fwft")) u_fwft (
    .clk(clk), .rst(f_rst), .wr_en(f_wr_en), .rd_en(f_rd_en), .data(f_data),
    .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_almost_full)
`ifdef SYNC_FIFO_DATA_COUNT_EN
    , .data_count(f_data_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; f_rst = 1'b1;
    repeat (20) tick();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if (f_empty !== 1'b1) begin failures++; $display("FAIL reset_fwft_empty got=%b exp=1", f_empty); end
    rst = 1'b0; f_rst = 1'b0;
    repeat (3) tick();
    checks++; if ({empty, full, almost_full} !== 3'b100) begin failures++; $display("FAIL post_reset_flags got=%b exp=100", {empty, full, almost_full}); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL post_reset_dout got=%h exp=00", dout); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      data = 8'(i); wr_en = 1'b1;
      tick();
      checks++; if (empty !== 1'b0) begin failures++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, empty); end
      checks++; if (almost_full !== (i >= 7)) begin failures++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, almost_full, (i >= 7)); end
      checks++; if (full !== (i == 8)) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == 8)); end
`ifdef SYNC_FIFO_DATA_COUNT_EN
      checks++; if (data_count !== 4'(i)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, data_count, i); end
`endif
    end
    data = 8'h09;
    tick();
    wr_en = 1'b0;
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_overflow_full got=%b exp=1", full); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
      tick();
      checks++; if (dout !== 8'(i)) begin failures++; $display("FAIL drain_dout[%0d] got=%h exp=%h", i, dout, 8'(i)); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL drain_full[%0d] got=%b exp=0", i, full); end
      checks++; if (empty !== (i == 8)) begin failures++; $display("FAIL drain_empty[%0d] got=%b exp=%b", i, empty, (i == 8)); end
    end
    tick();
    rd_en = 1'b0;
    checks++; if (dout !== 8'h08) begin failures++; $display("FAIL drain_underflow_dout got=%h exp=08", dout); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_underflow_empty got=%b exp=1", empty); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_v;
    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < 3; k++) begin
        data = 8'(8'h10 + r * 3 + k); wr_en = 1'b1;
        tick();
      end
      wr_en = 1'b0;
      checks++; if ({empty, full, almost_full} !== 3'b000) begin failures++; $display("FAIL wrap_flags_w[%0d] got=%b exp=000", r, {empty, full, almost_full}); end
      for (int k = 0; k < 3; k++) begin
        rd_en = 1'b1;
        tick();
        exp_v = 8'(8'h10 + r * 3 + k);
        checks++; if (dout !== exp_v) begin failures++; $display("FAIL wrap_dout[%0d.%0d] got=%h exp=%h", r, k, dout, exp_v); end
      end
      rd_en = 1'b0;
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty[%0d] got=%b exp=1", r, empty); end
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 4; k++) begin
      data = 8'(8'h30 + k); wr_en = 1'b1;
      tick();
    end
    data = 8'h34; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (dout !== 8'h30) begin failures++; $display("FAIL simul4_dout got=%h exp=30", dout); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (empty !== 1'b0) begin failures++; $display("FAIL simul4_occ[%0d] got_empty=%b exp=0", k, empty); end
      rd_en = 1'b1;
      tick();
      checks++; if (dout !== 8'(8'h30 + k)) begin failures++; $display("FAIL simul4_dout[%0d] got=%h exp=%h", k, dout, 8'(8'h30 + k)); end
    end
    rd_en = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL simul4_final_empty got=%b exp=1", empty); end

    data = 8'h40; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (dout !== 8'h34) begin failures++; $display("FAIL simul_empty_dout got=%h exp=34", dout); end
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL simul_empty_flag got=%b exp=0", empty); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if ({dout, empty} !== {8'h40, 1'b1}) begin failures++; $display("FAIL simul_empty_pop got=%h/%b exp=40/1", dout, empty); end

    for (int k = 0; k < 8; k++) begin
      data = 8'(8'h50 + k); wr_en = 1'b1;
      tick();
    end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL simul_full_pre got=%b exp=1", full); end
    data = 8'h60; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL simul_full_flag got=%b exp=0", full); end
    checks++; if (almost_full !== 1'b1) begin failures++; $display("FAIL simul_full_afull got=%b exp=1", almost_full); end
    checks++; if (dout !== 8'h50) begin failures++; $display("FAIL simul_full_dout got=%h exp=50", dout); end
    for (int k = 1; k <= 7; k++) begin
      rd_en = 1'b1;
      tick();
      checks++; if (dout !== 8'(8'h50 + k)) begin failures++; $display("FAIL simul_full_drain[%0d] got=%h exp=%h", k, dout, 8'(8'h50 + k)); end
    end
    rd_en = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL simul_full_dropped got_empty=%b exp=1", empty); end
  endtask

  task automatic test_fwft();
    f_data = 8'hA5; f_wr_en = 1'b1;
    tick();
    f_wr_en = 1'b0;
    checks++; if (f_empty !== 1'b0) begin failures++; $display("FAIL fwft_empty got=%b exp=0", f_empty); end
    checks++; if (f_dout !== 8'hA5) begin failures++; $display("FAIL fwft_dout got=%h exp=a5", f_dout); end
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    checks++; if (f_empty !== 1'b1) begin failures++; $display("FAIL fwft_pop_empty got=%b exp=1", f_empty); end
    for (int k = 1; k <= 5; k++) begin
      f_data = 8'(k); f_wr_en = 1'b1;
      tick();
      checks++; if (f_dout !== 8'h01) begin failures++; $display("FAIL fwft_head[%0d] got=%h exp=01", k, f_dout); end
    end
    f_wr_en = 1'b0;
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    checks++; if (f_dout !== 8'h02) begin failures++; $display("FAIL fwft_next got=%h exp=02", f_dout); end
    f_data = 8'h06; f_wr_en = 1'b1;
    tick();
    f_wr_en = 1'b0;
    checks++; if (f_empty !== 1'b0) begin failures++; $display("FAIL fwft_prerst_empty got=%b exp=0", f_empty); end
    #2 f_rst = 1'b1;
    #1;
    checks++; if (f_empty !== 1'b1) begin failures++; $display("FAIL fwft_async_empty got=%b exp=1", f_empty); end
    checks++; if (f_full !== 1'b0) begin failures++; $display("FAIL fwft_async_full got=%b exp=0", f_full); end
    tick();
    f_rst = 1'b0;
    tick();
    checks++; if (f_empty !== 1'b1) begin failures++; $display("FAIL fwft_post_rst_empty got=%b exp=1", f_empty); end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data = 8'h00;
    f_rst = 1'b1; f_wr_en = 1'b0; f_rd_en = 1'b0; f_data = 8'h00;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_fwft();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
